// File: rtl/fifo_rd_ctrl.sv
// Read-side controller between a registered-read FIFO and a VGA pixel consumer.
// Keeps a two-entry pixel buffer ahead of the consumer and tracks frames and underruns.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic                  pix_req,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt,
  output logic                  frame_done,
  output logic [1:0]            state
);

  localparam logic [18:0] FramePixels = 19'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    STREAM     = 2'd2,
    RESYNC     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [18:0]           pixCnt_q, pixCnt_d;
  logic [DATA_WIDTH-1:0] pixData_q, pixData_d;
  logic                  pixValid_q, pixValid_d;
  logic                  underrun_q, underrun_d;
  logic                  frameDone_q, frameDone_d;
  logic [15:0]           underrunCnt_q, underrunCnt_d;

  logic        streaming, pop, starve;
  logic [2:0]  level;
  logic [18:0] pixInc;

  // Reads are only launched when the landing slot is guaranteed free, so the buffer never overflows.
  always_comb begin
    streaming = enable && (state_q == STREAM);
    pop       = streaming && pix_req && (occ_q != 2'd0);
    starve    = streaming && pix_req && (occ_q == 2'd0);
    level     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_r_en = streaming && !fifo_empty && (level < 3'd2);
    pixInc    = pixCnt_q + 19'd1;
  end

  always_comb begin
    state_d       = state_q;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    occ_d         = occ_q;
    inflight_d    = fifo_r_en;
    pixCnt_d      = pixCnt_q;
    pixData_d     = '0;
    pixValid_d    = 1'b0;
    underrun_d    = 1'b0;
    frameDone_d   = 1'b0;
    underrunCnt_d = underrunCnt_q;

    if (!enable) begin
      state_d    = IDLE;
      occ_d      = 2'd0;
      inflight_d = 1'b0;
      pixCnt_d   = '0;
    end else begin
      if (pop) begin
        pixData_d  = buf0_q;
        pixValid_d = 1'b1;
        buf0_d     = buf1_q;
        occ_d      = occ_q - 2'd1;
        pixCnt_d   = pixInc;
      end
      // Landing data goes behind whatever survives this cycle's pop.
      if (inflight_q && (state_q != IDLE)) begin
        if (occ_d == 2'd0) buf0_d = fifo_data;
        else               buf1_d = fifo_data;
        occ_d = occ_d + 2'd1;
      end

      case (state_q)
        IDLE: state_d = WAIT_FRAME;
        WAIT_FRAME: begin
          if (frame_start) begin
            state_d  = STREAM;
            pixCnt_d = '0;
          end
        end
        STREAM: begin
          if (starve) begin
            state_d    = RESYNC;
            underrun_d = 1'b1;
            if (underrunCnt_q != 16'hFFFF) underrunCnt_d = underrunCnt_q + 16'd1;
          end else if (pop && (pixInc == FramePixels)) begin
            frameDone_d = 1'b1;
            pixCnt_d    = '0;
            state_d     = WAIT_FRAME;
          end
          if (frame_start) pixCnt_d = '0;
        end
        RESYNC: begin
          if (frame_start) begin
            state_d  = STREAM;
            pixCnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q       <= IDLE;
      buf0_q        <= '0;
      buf1_q        <= '0;
      occ_q         <= 2'd0;
      inflight_q    <= 1'b0;
      pixCnt_q      <= '0;
      pixData_q     <= '0;
      pixValid_q    <= 1'b0;
      underrun_q    <= 1'b0;
      frameDone_q   <= 1'b0;
      underrunCnt_q <= '0;
    end else begin
      state_q       <= state_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
      pixCnt_q      <= pixCnt_d;
      pixData_q     <= pixData_d;
      pixValid_q    <= pixValid_d;
      underrun_q    <= underrun_d;
      frameDone_q   <= frameDone_d;
      underrunCnt_q <= underrunCnt_d;
    end
  end

  assign pix_data     = pixData_q;
  assign pix_valid    = pixValid_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrunCnt_q;
  assign frame_done   = frameDone_q;
  assign state        = state_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a small registered-read FIFO model
// and a scoreboard of expected pixel outputs, one entry per driven cycle.
module tb_fifo_rd_ctrl;

  logic       rclk;
  logic       rrst_n;
  logic       enable;
  logic       frame_start;
  logic       pix_req;
  logic       fifo_empty;
  logic [3:0] fifo_data;
  logic       fifo_r_en;
  logic [3:0] pix_data;
  logic       pix_valid;
  logic       underrun;
  logic [15:0] underrun_cnt;
  logic       frame_done;
  logic [1:0] state;

  typedef struct packed {
    logic       v;
    logic [3:0] d;
  } exp_t;

  exp_t       expQ[$];
  logic [3:0] fifoQ[$];
  int         assertCount;
  int         failCount;
  int         rdCount;

  fifo_rd_ctrl #(
    .DATA_WIDTH(4),
    .H_ACTIVE  (4),
    .V_ACTIVE  (2)
  ) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .enable      (enable),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_r_en   (fifo_r_en),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt),
    .frame_done  (frame_done),
    .state       (state)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkVal("pix_valid", 32'(pix_valid), 32'(e.v));
      checkVal("pix_data", 32'(pix_data), 32'(e.d));
    end
  endtask

  task automatic preload(input logic [3:0] v);
    fifoQ.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample the read strobe before the edge, model the registered FIFO read after it.
  task automatic tick();
    logic rdEn;
    #1;
    rdEn = fifo_r_en;
    if (rdEn) rdCount++;
    @(posedge rclk);
    #1;
    if (rdEn) fifo_data = (fifoQ.size() > 0) ? fifoQ.pop_front() : 4'h0;
    fifo_empty = (fifoQ.size() == 0);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic req, input logic fs, input logic expV, input logic [3:0] expD);
    pix_req     = req;
    frame_start = fs;
    expQ.push_back('{v: expV, d: expD});
    tick();
    pix_req     = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rdCount     = 0;
    rrst_n      = 1'b0;
    enable      = 1'b0;
    frame_start = 1'b0;
    pix_req     = 1'b0;
    fifo_empty  = 1'b1;
    fifo_data   = 4'h0;

    // Reset state
    #12;
    checkVal("rst_state", 32'(state), 32'd0);
    checkVal("rst_r_en", 32'(fifo_r_en), 32'd0);
    checkVal("rst_valid", 32'(pix_valid), 32'd0);
    checkVal("rst_ucnt", 32'(underrun_cnt), 32'd0);
    #10 rrst_n = 1'b1;
    @(posedge rclk);
    #2;

    // Basic streaming of 1,2,3
    preload(4'h1); preload(4'h2); preload(4'h3);
    enable = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    checkVal("to_wait", 32'(state), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
    checkVal("to_stream", 32'(state), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h2);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h3);
    checkVal("basic_ucnt", 32'(underrun_cnt), 32'd0);

    // Underrun with empty buffer and FIFO
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    checkVal("ur_pulse", 32'(underrun), 32'd1);
    checkVal("ur_cnt", 32'(underrun_cnt), 32'd1);
    checkVal("ur_state", 32'(state), 32'd3);
    for (int i = 4; i < 12; i++) preload(4'(i));
    #1;
    checkVal("resync_r_en", 32'(fifo_r_en), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    checkVal("resync_no_ur", 32'(underrun), 32'd0);
    checkVal("resync_cnt", 32'(underrun_cnt), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
    checkVal("resync_exit", 32'(state), 32'd2);

    // Full 4x2 frame
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 4; i < 11; i++) applyStimulus(1'b1, 1'b0, 1'b1, 4'(i));
    checkVal("fd_early", 32'(frame_done), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hB);
    checkVal("fd_pulse", 32'(frame_done), 32'd1);
    checkVal("fd_state", 32'(state), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    checkVal("fd_clear", 32'(frame_done), 32'd0);

    // Flow control: buffer fills to two and reads stop
    preload(4'hC); preload(4'hD); preload(4'hE); preload(4'hF); preload(4'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
    rdCount = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    checkVal("fc_reads", 32'(rdCount), 32'd2);
    checkVal("fc_r_en", 32'(fifo_r_en), 32'd0);

    // Disable with a read in flight; old data must not reappear
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hC);
    enable = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    checkVal("dis_state", 32'(state), 32'd0);
    checkVal("dis_ucnt", 32'(underrun_cnt), 32'd1);
    enable = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h1);
    checkVal("reen_ucnt", 32'(underrun_cnt), 32'd1);

    // Asynchronous reset between edges mid-stream
    preload(4'h7); preload(4'h8);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);
    #1 rrst_n = 1'b0;
    #1;
    checkVal("arst_valid", 32'(pix_valid), 32'd0);
    checkVal("arst_data", 32'(pix_data), 32'd0);
    checkVal("arst_ucnt", 32'(underrun_cnt), 32'd0);
    checkVal("arst_state", 32'(state), 32'd0);
    checkVal("arst_r_en", 32'(fifo_r_en), 32'd0);
    #3 rrst_n = 1'b1;
    @(posedge rclk);
    #2;
    checkVal("post_rst_state", 32'(state), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    checkVal("post_rst_ur", 32'(underrun), 32'd1);
    checkVal("post_rst_ucnt", 32'(underrun_cnt), 32'd1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
